// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges never-stalled load returns with ALU results.
// ALU results that lose to a load wait in a small circular queue, and the
// queue can be searched by decode to find writes that are still pending.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        alu_stall,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic [31:0] q_data1,
    output logic [31:0] q_data2,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    rdMem_q   [DEPTH];
    logic [31:0]   dataMem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrEn_q, wrEn_d;
    logic [4:0]    wrAddr_q, wrAddr_d;
    logic [31:0]   wrData_q, wrData_d;

    logic ldWrite;
    logic full;
    logic aluLive;
    logic pop;
    logic bypass;
    logic push;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign alu_stall = full && alu_valid && (alu_rd != 5'd0);
    assign ldWrite   = ld_valid && (ld_rd != 5'd0);
    // An rd==0 request is accepted but produces nothing, so it never counts as live.
    assign aluLive   = alu_valid && !alu_stall && (alu_rd != 5'd0);
    assign pop       = !ldWrite && !empty;
    assign bypass    = !ldWrite && empty && aluLive;
    assign push      = aluLive && !bypass;

    assign write_enable = wrEn_q;
    assign write_addr   = wrAddr_q;
    assign write_data   = wrData_q;

    // Pick this cycle's write (load, then queue head, then bypass) and advance the queue.
    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        if (ldWrite) begin
            wrEn_d   = 1'b1;
            wrAddr_d = ld_rd;
            wrData_d = ld_data;
        end else if (pop) begin
            wrEn_d   = 1'b1;
            wrAddr_d = rdMem_q[head_q];
            wrData_d = dataMem_q[head_q];
        end else if (bypass) begin
            wrEn_d   = 1'b1;
            wrAddr_d = alu_rd;
            wrData_d = alu_data;
        end

        head_d = pop  ? head_q + PW'(1) : head_q;
        tail_d = push ? tail_q + PW'(1) : tail_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue bookkeeping and the registered register-file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
        end
    end

    // Entry storage needs no reset; validity comes from the count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            rdMem_q[tail_q]   <= alu_rd;
            dataMem_q[tail_q] <= alu_data;
        end
    end

    // Scan from oldest to youngest so the youngest matching entry wins both queries.
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((q_addr1 != 5'd0) && (rdMem_q[head_q + PW'(i)] == q_addr1)) begin
                    q_hit1  = 1'b1;
                    q_data1 = dataMem_q[head_q + PW'(i)];
                end
                if ((q_addr2 != 5'd0) && (rdMem_q[head_q + PW'(i)] == q_addr2)) begin
                    q_hit2  = 1'b1;
                    q_data2 = dataMem_q[head_q + PW'(i)];
                end
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, sets the ALU-result queue depth in entries (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high; one clock domain only.
REQ-004 SHALL have port alu_valid  input  1  ALU writeback request this cycle.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU result.
REQ-007 SHALL have port ld_valid  input  1  load-return writeback request this cycle; never stalled.
REQ-008 SHALL have port ld_rd  input  5  load destination register.
REQ-009 SHALL have port ld_data  input  32  load data.
REQ-010 SHALL have port alu_stall  output  1  queue full; ALU request not accepted.
REQ-011 SHALL have port write_enable  output  1  register-file write strobe, registered.
REQ-012 SHALL have port write_addr  output  5  register-file write address, registered.
REQ-013 SHALL have port write_data  output  32  register-file write data, registered.
REQ-014 SHALL have ports q_addr1 and q_addr2  input  5 each  decode-stage source registers to check.
REQ-015 SHALL have ports q_hit1 and q_hit2  output  1 each  the queried register has a queued write.
REQ-016 SHALL have ports q_data1 and q_data2  output  32 each  data of the youngest queued write to the queried register, 0 when no hit.
REQ-017 SHALL have port empty  output  1  queue holds no entries.

Function
REQ-018 SHALL keep a circular FIFO of DEPTH {rd, data} entries with head and tail pointers and a count from 0 to DEPTH.
REQ-019 SHALL make alu_stall combinational: alu_stall = (count == DEPTH) and alu_valid and (alu_rd != 0).
REQ-020 SHALL treat an ALU request as accepted when alu_valid is high and alu_stall is low; the producer holds alu_rd and alu_data stable while stalled.
REQ-021 SHALL accept and discard an ALU request with alu_rd == 0, with no enqueue and no write, even when the queue is full.
REQ-022 SHALL choose the write for each cycle in this priority order: a valid load with ld_rd != 0, then the queue head, then an accepted ALU request bypassing an empty queue.
REQ-023 SHALL enqueue an accepted ALU request with alu_rd != 0 when it is not bypassed; in the same cycle it can be neither bypassed nor popped.
REQ-024 SHALL allow a pop and a push in the same cycle, leaving count unchanged.
REQ-025 SHALL wrap both pointers modulo DEPTH; count never exceeds DEPTH and never goes below 0.
REQ-026 SHALL present the chosen write on write_enable, write_addr and write_data at the next rising edge (1-cycle latency); with no write chosen, write_enable = 0 and the address and data hold their previous values.
REQ-027 SHALL NOT write when ld_valid is high and ld_rd == 0, and SHALL still serve the queue that cycle.
REQ-028 SHALL assert q_hitN combinationally when q_addrN != 0 matches any valid queue entry, and SHALL drive q_dataN from the youngest matching entry.
REQ-029 SHALL NOT include the registered output or same-cycle inputs in the query; the register file bypass covers the output.
REQ-030 SHALL rely on upstream to guarantee no WAW ordering between a load and a queued ALU write to the same rd, using q_hit to stall.
REQ-031 SHALL drive empty = (count == 0).

Reset
REQ-032 SHALL, while rst is high and without waiting for a clock edge, set count, pointers, write_enable, write_addr and write_data to 0; alu_stall, q_hit and q_data then read 0 and empty reads 1.
REQ-033 SHALL discard queued entries when reset asserts mid-operation; the first write after release comes only from a new request.

Verification
REQ-034 SHALL pass: ALU rd=5 data=0x11 with queue empty and no load -> next cycle write_enable=1, addr=5, data=0x11, empty stays 1.
REQ-035 SHALL pass: load rd=3 data=0xAA with ALU rd=7 data=0x22 in the same cycle -> cycle+1 writes r3=0xAA, cycle+2 writes r7=0x22; q_hit for r7 is 1 during cycle+1.
REQ-036 SHALL pass: 4 loads back-to-back with 5 ALU requests (DEPTH=4) -> alu_stall=1 on the 5th, the held request is accepted after the first pop, and all ALU writes drain in FIFO order.
REQ-037 SHALL pass: queued writes r9=0x1 then r9=0x2 -> q_addr1=9 gives q_hit1=1, q_data1=0x2; q_addr2=0 gives q_hit2=0.
REQ-038 SHALL pass: ALU rd=0 while the queue is full -> alu_stall=0 and no enqueue; load rd=0 -> no write, and the queue head is written instead.
REQ-039 SHALL pass: rst pulsed mid-cycle with 3 entries queued -> outputs go to 0 at once, empty=1, and no stale writes appear after release.
